dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the core's single-port data memory between two requesters: the RISC-V core
//  (load/store port) and an external port (program loader / debug / DMA).
//  Arbitrates every cycle and routes 1-cycle-latency read data back to its owner.
//  Stalls the core while it is denied. Supports locked external bursts, with a timeout.
//  Sits between riscv (wr/rd/addr/wr_data) and the data memory.
// PARAMETERS
//  DATA_W      32  data width of all data buses
//  ADDR_W      9   memory address width (matches core addr[8:0])
//  STARVE_LIM  4   ext waiting cycles before it beats the core (>=1)
//  LOCK_MAX    64  max cycles ext may hold lock before forced release (>=2)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  core_req     in   1       core access request
//  core_we      in   1       1=write, 0=read
//  core_addr    in   ADDR_W  core address
//  core_wdata   in   DATA_W  core write data
//  core_gnt     out  1       core access accepted this cycle
//  core_stall   out  1       core_req & ~core_gnt; core holds its request
//  core_rvalid  out  1       core read data valid (cycle after grant)
//  core_rdata   out  DATA_W  mem_rdata when core_rvalid, else 0
//  ext_req/ext_we/ext_addr/ext_wdata  in  1/1/ADDR_W/DATA_W  external request, same meaning
//  ext_lock     in   1       request exclusive ownership after next ext grant
//  ext_gnt      out  1       ext access accepted this cycle
//  ext_rvalid   out  1       ext read data valid
//  ext_rdata    out  DATA_W  mem_rdata when ext_rvalid, else 0
//  mem_wr       out  1       memory write strobe
//  mem_rd       out  1       memory read strobe
//  mem_addr     out  ADDR_W  granted address (0 when idle)
//  mem_wdata    out  DATA_W  granted write data (0 when idle)
//  mem_rdata    in   DATA_W  memory read data, valid 1 cycle after mem_rd
// BEHAVIOUR
//  - Grants are combinational from state + requests. At most one gnt is high.
//    mem_* mux the granted requester: mem_wr=we, mem_rd=~we. No grant -> mem_wr=mem_rd=0, addr/wdata=0.
//  - States: ARB, LOCK.
//    ARB: core wins, unless wait_cnt==STARVE_LIM and ext_req, then ext wins.
//    LOCK: ext granted whenever ext_req. Core never granted.
//  - wait_cnt: +1 each cycle ext_req & ~ext_gnt, saturating at STARVE_LIM. Cleared on ext_gnt.
//  - ARB->LOCK: clock edge of a cycle where ext_gnt & ext_lock & ~inhibit.
//  - LOCK->ARB: at the edge ending the first cycle with ext_lock=0. Ext keeps priority in that cycle.
//  - lock_cnt counts cycles in LOCK. When it reaches LOCK_MAX the next state is ARB
//    and inhibit is set. inhibit clears once ext_lock is sampled 0. lock_cnt clears on entry to LOCK.
//  - Read owner (NONE/CORE/EXT) is registered on every read grant and set to NONE otherwise.
//    Next cycle the matching rvalid=1. Writes give no response.
//    Back-to-back reads by alternating owners are each routed correctly.
//  - Reset values: state=ARB, wait_cnt=0, lock_cnt=0, inhibit=0, owner=NONE.
//    All rvalid=0 and all rdata=0. Gnts and mem strobes are 0 when no requests are present.
//  - Reset mid-read: the pending rvalid is dropped. Reset during LOCK: returns to ARB.
// STRUCTURE
//  - Package riscv_mem_pkg: typedef enum arb_state_t {ARB,LOCK}; typedef enum owner_t {NONE,CORE,EXT}.
//  - One sub-module: sat_counter #(W,MAX) (inc, clr, at_max); used for both wait_cnt and lock_cnt.
//  - Rest flat: state reg, owner reg, inhibit reg, combinational grant/mux.
// TESTING
//  1. Reset held, all reqs 1 -> state ARB. All gnt/rvalid/mem_wr/mem_rd=0.
//  2. core_req read addr 0x010, mem_rdata=0xDEADBEEF next cycle
//     -> core_gnt=1, mem_rd=1, mem_addr=0x010. Next cycle core_rvalid=1, core_rdata=0xDEADBEEF, ext_rvalid=0.
//  3. core_req & ext_req held continuously, STARVE_LIM=4
//     -> core granted 4 cycles, ext granted 5th cycle (core_stall=1 there), then core again. Pattern repeats.
//  4. ext_req+ext_lock write burst of 3; core_req held throughout
//     -> core_gnt=0 / core_stall=1 during lock. Core granted the cycle after ext_lock=0 is sampled.
//  5. ext_lock stuck 1, LOCK_MAX=64 -> forced to ARB after 64 LOCK cycles. Core gets a grant.
//     No re-lock until ext_lock pulses 0.
//  6. Core read granted, reset asserted the following cycle -> core_rvalid=0, core_rdata=0, owner=NONE.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory arbiter: arbitration state and read-response owner.
package riscv_mem_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        EXT  = 2'd2
    } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    logic [W-1:0] r_cnt;

    assign o_at_max = (r_cnt == W'(MAX));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !o_at_max)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core and an external port,
// with starvation relief for ext, locked ext bursts and a lock timeout.
module dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int STARVE_LIM = 4,
    parameter int LOCK_MAX   = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_stall,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    input  logic              i_ext_lock,
    output logic              o_ext_gnt,
    output logic              o_ext_rvalid,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic              o_mem_wr,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    arb_state_t r_state, w_state_nxt;
    owner_t     r_owner;
    logic       r_inhibit;
    logic       w_core_gnt, w_ext_gnt;
    logic       w_wait_max, w_lock_max, w_lock_expire;

    sat_counter #(
        .W   ($clog2(STARVE_LIM + 1)),
        .MAX (STARVE_LIM)
    ) u_wait_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_inc    (i_ext_req & ~w_ext_gnt),
        .i_clr    (w_ext_gnt),
        .o_at_max (w_wait_max)
    );

    // Saturates at LOCK_MAX-1 so at_max marks the last permitted LOCK cycle.
    sat_counter #(
        .W   ($clog2(LOCK_MAX)),
        .MAX (LOCK_MAX - 1)
    ) u_lock_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_inc    (r_state == LOCK),
        .i_clr    (r_state == ARB),
        .o_at_max (w_lock_max)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ARB;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_core_gnt    = 1'b0;
        w_ext_gnt     = 1'b0;
        w_lock_expire = 1'b0;
        case (r_state)
            ARB: begin
                if (i_ext_req && (w_wait_max || !i_core_req))
                    w_ext_gnt = 1'b1;
                else
                    w_core_gnt = i_core_req;
                if (w_ext_gnt && i_ext_lock && !r_inhibit)
                    w_state_nxt = LOCK;
            end
            LOCK: begin
                w_ext_gnt = i_ext_req;
                if (!i_ext_lock) begin
                    w_state_nxt = ARB;
                end else if (w_lock_max) begin
                    w_state_nxt   = ARB;
                    w_lock_expire = 1'b1;
                end
            end
            default: w_state_nxt = ARB;
        endcase
        // No grants may escape while reset is held, whatever the requests.
        if (i_rst) begin
            w_core_gnt = 1'b0;
            w_ext_gnt  = 1'b0;
        end
    end

    // A forced release blocks re-locking until ext drops its lock request once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_inhibit <= 1'b0;
        else if (w_lock_expire)
            r_inhibit <= 1'b1;
        else if (!i_ext_lock)
            r_inhibit <= 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_owner <= NONE;
        else if (w_core_gnt && !i_core_we)
            r_owner <= CORE;
        else if (w_ext_gnt && !i_ext_we)
            r_owner <= EXT;
        else
            r_owner <= NONE;
    end

    always_comb begin
        o_mem_wr    = 1'b0;
        o_mem_rd    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_core_gnt) begin
            o_mem_wr    = i_core_we;
            o_mem_rd    = ~i_core_we;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
        end else if (w_ext_gnt) begin
            o_mem_wr    = i_ext_we;
            o_mem_rd    = ~i_ext_we;
            o_mem_addr  = i_ext_addr;
            o_mem_wdata = i_ext_wdata;
        end
    end

    assign o_core_gnt    = w_core_gnt;
    assign o_ext_gnt     = w_ext_gnt;
    assign o_core_stall  = i_core_req & ~w_core_gnt;
    assign o_core_rvalid = (r_owner == CORE);
    assign o_ext_rvalid  = (r_owner == EXT);
    assign o_core_rdata  = o_core_rvalid ? i_mem_rdata : '0;
    assign o_ext_rdata   = o_ext_rvalid  ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 9;
    localparam int STARVE_LIM = 4;
    localparam int LOCK_MAX   = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we, ext_req, ext_we, ext_lock;
    logic [ADDR_W-1:0] core_addr, ext_addr;
    logic [DATA_W-1:0] core_wdata, ext_wdata, mem_rdata;
    logic              core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid, mem_wr, mem_rd;
    logic [DATA_W-1:0] core_rdata, ext_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_locked, m_inhibit;
    int m_wait, m_lock_cyc, m_pend;   // m_pend: 0 none, 1 core, 2 ext

    // Values seen at the last check point, for directed checks
    logic obs_cg, obs_eg, obs_crv;
    logic [DATA_W-1:0] obs_crd;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wdata(core_wdata), .o_core_gnt(core_gnt), .o_core_stall(core_stall),
        .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
        .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr),
        .i_ext_wdata(ext_wdata), .i_ext_lock(ext_lock), .o_ext_gnt(ext_gnt),
        .o_ext_rvalid(ext_rvalid), .o_ext_rdata(ext_rdata),
        .o_mem_wr(mem_wr), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_locked   = 0;
        m_inhibit  = 0;
        m_wait     = 0;
        m_lock_cyc = 0;
        m_pend     = 0;
    endfunction

    // One clock cycle: check outputs at negedge, advance model at posedge.
    task automatic step();
        bit cg, eg, crv, erv;
        @(negedge clk);
        cg = 0;
        eg = 0;
        if (!rst) begin
            if (m_locked)
                eg = ext_req;
            else if (ext_req && (m_wait >= STARVE_LIM || !core_req))
                eg = 1;
            else
                cg = core_req;
        end
        crv = (m_pend == 1) && !rst;
        erv = (m_pend == 2) && !rst;
        chk("core_gnt",    core_gnt,   cg);
        chk("ext_gnt",     ext_gnt,    eg);
        chk("core_stall",  core_stall, core_req & ~cg);
        chk("mem_wr",      mem_wr,     cg ? core_we  : eg ? ext_we  : 1'b0);
        chk("mem_rd",      mem_rd,     cg ? !core_we : eg ? !ext_we : 1'b0);
        chk("mem_addr",    32'(mem_addr),  cg ? 32'(core_addr) : eg ? 32'(ext_addr) : 32'd0);
        chk("mem_wdata",   mem_wdata,  cg ? core_wdata : eg ? ext_wdata : 32'd0);
        chk("core_rvalid", core_rvalid, crv);
        chk("ext_rvalid",  ext_rvalid,  erv);
        chk("core_rdata",  core_rdata,  crv ? mem_rdata : 32'd0);
        chk("ext_rdata",   ext_rdata,   erv ? mem_rdata : 32'd0);
        obs_cg  = core_gnt;
        obs_eg  = ext_gnt;
        obs_crv = core_rvalid;
        obs_crd = core_rdata;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_pend = (cg && !core_we) ? 1 : (eg && !ext_we) ? 2 : 0;
            if (eg)
                m_wait = 0;
            else if (ext_req && m_wait < STARVE_LIM)
                m_wait++;
            if (!ext_lock)
                m_inhibit = 0;
            if (m_locked) begin
                m_lock_cyc++;
                if (!ext_lock)
                    m_locked = 0;
                else if (m_lock_cyc == LOCK_MAX) begin
                    m_locked  = 0;
                    m_inhibit = 1;
                end
            end else if (eg && ext_lock && !m_inhibit) begin
                m_locked   = 1;
                m_lock_cyc = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        ext_req  = 0; ext_we  = 0; ext_addr  = '0; ext_wdata  = '0;
        ext_lock = 0; mem_rdata = '0;
    endtask

    initial begin
        int run, gnt_ext_cnt;
        model_reset();
        idle_inputs();

        // Reset held with every request asserted
        rst = 1;
        core_req = 1; ext_req = 1; ext_lock = 1; mem_rdata = 32'h1234_5678;
        repeat (3) step();
        chk("rst_core_gnt", obs_cg, 1'b0);
        chk("rst_ext_gnt",  obs_eg, 1'b0);
        idle_inputs();
        rst = 0;
        step();

        // Single core read
        core_req = 1; core_we = 0; core_addr = 9'h010;
        step();
        chk("t2_gnt", obs_cg, 1'b1);
        core_req = 0; mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("t2_rvalid", obs_crv, 1'b1);
        chk("t2_rdata",  obs_crd, 32'hDEAD_BEEF);

        // Both requesting: ext wins every (STARVE_LIM+1)th cycle
        core_req = 1; ext_req = 1; ext_we = 1; ext_addr = 9'h1AB; ext_wdata = 32'hA5A5_0001;
        gnt_ext_cnt = 0;
        for (int i = 0; i < 3 * (STARVE_LIM + 1); i++) begin
            step();
            if (obs_eg) gnt_ext_cnt++;
        end
        chk("t3_ext_share", gnt_ext_cnt, 3);

        // Locked burst of 3 writes with core held
        idle_inputs();
        step();
        core_req = 1; core_addr = 9'h022;
        ext_req = 1; ext_we = 1; ext_lock = 1; ext_addr = 9'h100;
        for (int i = 0; i < 8 && !obs_eg; i++) step();
        ext_addr = 9'h101; step();
        chk("t4_beat2", obs_eg, 1'b1);
        ext_lock = 0; ext_addr = 9'h102; step();
        chk("t4_beat3", obs_eg, 1'b1);
        ext_req = 0; step();
        chk("t4_core_back", obs_cg, 1'b1);

        // Lock stuck high: forced release after LOCK_MAX cycles, no re-lock until dropped
        idle_inputs();
        step();
        core_req = 1; ext_req = 1; ext_we = 1; ext_lock = 1;
        for (int i = 0; i < 8 && !obs_eg; i++) step();
        run = 1;
        for (int i = 0; i < LOCK_MAX + 4 && obs_eg; i++) begin
            step();
            if (obs_eg) run++;
        end
        chk("t5_lock_run", run, LOCK_MAX + 1);
        chk("t5_core_gnt", obs_cg, 1'b1);
        gnt_ext_cnt = 0;
        for (int i = 0; i < 2 * (STARVE_LIM + 1); i++) begin
            step();
            if (obs_eg) gnt_ext_cnt++;
        end
        chk("t5_no_relock", gnt_ext_cnt, 2);
        ext_lock = 0; step();
        ext_lock = 1;
        repeat (2 * (STARVE_LIM + 1)) step();

        // Reset the cycle after a core read grant
        idle_inputs();
        step();
        core_req = 1; core_we = 0; core_addr = 9'h033;
        step();
        chk("t6_gnt", obs_cg, 1'b1);
        core_req = 0; rst = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        chk("t6_rvalid", obs_crv, 1'b0);
        chk("t6_rdata",  obs_crd, 32'd0);
        rst = 0;
        step();

        // Random traffic with sticky lock requests and occasional reset
        for (int i = 0; i < 3000; i++) begin
            core_req   = ($urandom_range(0, 9) < 7);
            core_we    = $urandom_range(0, 1);
            core_addr  = ADDR_W'($urandom);
            core_wdata = $urandom;
            ext_req    = ($urandom_range(0, 1) == 1);
            ext_we     = $urandom_range(0, 1);
            ext_addr   = ADDR_W'($urandom);
            ext_wdata  = $urandom;
            if ($urandom_range(0, 7) == 0) ext_lock = ~ext_lock;
            mem_rdata  = $urandom;
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
